// File: rtl/rv_pkg.sv
// Shared fetch-side definitions: machine width, canonical NOP and the
// instruction fetch unit state encoding.
package rv_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0 -- payload carried by misaligned-fetch fault entries
  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IFU_IDLE  = 2'd0,
    IFU_REQ   = 2'd1,
    IFU_DRAIN = 2'd2,
    IFU_HALT  = 2'd3
  } ifu_state_e;

  // Instruction fetch targets must be word aligned.
  function automatic logic misaligned(input logic [1:0] pc_lsbs);
    return pc_lsbs != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO between instruction memory and the decoder. The head entry
// is held in its own register so the consumer never sees a combinational
// path from the write side; a freshly written word becomes visible at the
// head one edge after it lands in storage.
module fetch_fifo #(
  parameter  int WIDTH = 65,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] push_data,
  output logic [CW-1:0]    count,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             head_vld_q, head_vld_d;
  logic [WIDTH-1:0] head_data_q, head_data_d;
  logic             pop_ok;
  logic             push_ok;

  // Flush wins over everything; a pop only counts against a visible head.
  assign pop_ok  = pop & head_vld_q & ~flush;
  assign push_ok = push & ~flush & ((count_q != CW'(DEPTH)) | pop_ok);

  // Next pointers, occupancy and head register contents.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    head_vld_d  = head_vld_q;
    head_data_d = head_data_q;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      head_vld_d = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
      // Head is refreshed from entries already in storage before this edge,
      // which gives the one-cycle head latency after a write.
      head_vld_d  = (count_q > CW'(pop_ok));
      head_data_d = mem_q[rd_ptr_q + AW'(pop_ok)];
    end
  end

  // Entry storage; contents need no reset because occupancy guards reads.
  always_ff @(posedge sys_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  // Pointer, occupancy and head registers with synchronous active-low reset.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      head_vld_q  <= 1'b0;
      head_data_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      head_vld_q  <= head_vld_d;
      head_data_q <= head_data_d;
    end
  end

  assign count      = count_q;
  assign head_valid = head_vld_q;
  assign head_data  = head_data_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, runs the single-outstanding
// req/ack read protocol to instruction memory, and queues returned words
// with their PCs for the control unit. Redirects flush the queue; a request
// already on the bus is allowed to finish and its data is discarded.
module inst_fetch_unit #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redir_valid,
  input  logic [XLEN-1:0] redir_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_fault
);

  import rv_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = 2 * XLEN + 1;

  ifu_state_e      state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            req_q, req_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            fault_pend_q, fault_pend_d;

  logic            push;
  logic [EW-1:0]   push_data;
  logic            pop_fire;
  logic [CW-1:0]   fifo_count;
  logic [CW-1:0]   count_after_ack;
  logic            room_after_ack;
  logic [EW-1:0]   head_data;
  logic            redir_bad;

  assign pop_fire  = inst_valid & inst_ready;
  assign redir_bad = misaligned(redir_pc[1:0]);

  // Occupancy once the word being acknowledged is written; the outstanding
  // request already holds a reserved slot, so this never exceeds the depth.
  assign count_after_ack = fifo_count + CW'(1) - CW'(pop_fire);
  assign room_after_ack  = (count_after_ack < CW'(FIFO_DEPTH));

  // Fetch sequencing: redirect first, then per-state issue/ack handling.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    req_d        = req_q;
    addr_d       = addr_q;
    fault_pend_d = fault_pend_q;
    push         = 1'b0;
    push_data    = {imem_rdata, fetch_pc_q, 1'b0};
    if (redir_valid) begin
      fetch_pc_d   = redir_pc;
      fault_pend_d = redir_bad;
      if (req_q && !imem_ack) begin
        // Bus transaction still open: keep it alive, drop its data later.
        state_d = IFU_DRAIN;
      end else if (redir_bad) begin
        state_d = IFU_HALT;
        req_d   = 1'b0;
      end else begin
        state_d = IFU_REQ;
        req_d   = 1'b1;
        addr_d  = redir_pc;
      end
    end else begin
      case (state_q)
        IFU_IDLE: begin
          if (fifo_count < CW'(FIFO_DEPTH)) begin
            state_d = IFU_REQ;
            req_d   = 1'b1;
            addr_d  = fetch_pc_q;
          end
        end
        IFU_REQ: begin
          if (imem_ack) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + XLEN'(4);
            if (room_after_ack) begin
              addr_d = fetch_pc_q + XLEN'(4);
            end else begin
              state_d = IFU_IDLE;
              req_d   = 1'b0;
            end
          end
        end
        IFU_DRAIN: begin
          if (imem_ack) begin
            if (fault_pend_q) begin
              state_d = IFU_HALT;
              req_d   = 1'b0;
            end else begin
              // Queue was flushed on redirect, so a slot is free.
              state_d = IFU_REQ;
              addr_d  = fetch_pc_q;
            end
          end
        end
        IFU_HALT: begin
          if (fault_pend_q) begin
            push         = 1'b1;
            push_data    = {XLEN'(RV_NOP), fetch_pc_q, 1'b1};
            fault_pend_d = 1'b0;
          end
        end
        default: begin
          state_d = IFU_IDLE;
          req_d   = 1'b0;
        end
      endcase
    end
  end

  // Fetch FSM and registered bus outputs.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      state_q      <= IFU_IDLE;
      fetch_pc_q   <= RESET_PC;
      req_q        <= 1'b0;
      addr_q       <= RESET_PC;
      fault_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      fault_pend_q <= fault_pend_d;
    end
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .push       (push),
    .pop        (pop_fire),
    .flush      (redir_valid),
    .push_data  (push_data),
    .count      (fifo_count),
    .head_valid (inst_valid),
    .head_data  (head_data)
  );

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign inst_data  = head_data[EW-1 -: XLEN];
  assign inst_pc    = head_data[XLEN:1];
  assign inst_fault = head_data[0];

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for the instruction fetch unit: a latency-programmable
// instruction memory responder, a consumer-side capture queue and
// hand-computed expectations per scenario.
module tb_inst_fetch_unit;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redir_valid = 1'b0;
  logic [31:0] redir_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_fault;

  int n_vec = 0;
  int n_err = 0;

  // memory responder state
  int          lat = 1;
  int          wcnt = 0;
  logic        ack_m = 1'b0;
  logic        force_ack = 1'b0;
  logic [31:0] rdata_m = '0;
  logic [31:0] ack_log[$];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic        fault;
  } ent_t;
  ent_t popped[$];

  assign imem_ack   = ack_m | force_ack;
  assign imem_rdata = rdata_m;

  always #5 sys_clk = ~sys_clk;

  inst_fetch_unit dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_data   (inst_data),
    .inst_pc     (inst_pc),
    .inst_fault  (inst_fault)
  );

  // Memory: ack after 'lat' wait cycles; word = 0x11 + addr/4.
  always @(posedge sys_clk) begin
    #1;
    if (!sys_rst) begin
      ack_m = 1'b0;
      wcnt  = 0;
    end else begin
      if (ack_m) wcnt = 0;
      if (imem_req) begin
        if (wcnt >= lat) begin
          ack_m   = 1'b1;
          rdata_m = 32'h11 + (imem_addr >> 2);
          ack_log.push_back(imem_addr);
        end else begin
          ack_m = 1'b0;
          wcnt++;
        end
      end else begin
        ack_m = 1'b0;
      end
    end
  end

  // Consumer capture: record what is really popped (redirect cycles drop pops).
  always @(negedge sys_clk) begin
    if (sys_rst && inst_valid && inst_ready && !redir_valid)
      popped.push_back('{inst_pc, inst_data, inst_fault});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge sys_clk);
      #2;
    end
  endtask

  task automatic hold_reset();
    sys_rst     = 1'b0;
    redir_valid = 1'b0;
    force_ack   = 1'b0;
    tick(2);
    ack_log.delete();
    popped.delete();
  endtask

  task automatic wait_pop(input int n, input string tag);
    int k = 0;
    while (popped.size() < n && k < 80) begin
      tick(1);
      k++;
    end
    chk(tag, 32'(popped.size() >= n), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired n_vec=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int n_req;

    // ---- 1: reset values, basic streaming, latency ----
    lat = 1; inst_ready = 1'b1;
    hold_reset();
    chk("rst_req",   32'(imem_req),   32'd0);
    chk("rst_addr",  imem_addr,       32'h0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_data",  inst_data,       32'h0);
    chk("rst_pc",    inst_pc,         32'h0);
    chk("rst_fault", 32'(inst_fault), 32'd0);
    sys_rst = 1'b1;
    tick(1);
    chk("t1_first_req",  32'(imem_req), 32'd1);
    chk("t1_first_addr", imem_addr,     32'h0);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (imem_ack) found = 1'b1;
      else tick(1);
    end
    chk("t1_ack_seen", 32'(found), 32'd1);
    tick(1);
    chk("t1_lat_n", 32'(inst_valid), 32'd0);
    tick(1);
    chk("t1_lat_n1",   32'(inst_valid), 32'd1);
    chk("t1_lat_pc",   inst_pc,         32'h0);
    chk("t1_lat_data", inst_data,       32'h11);
    wait_pop(4, "t1_pop_timeout");
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_addr%0d", i),  ack_log[i],         32'(4 * i));
      chk($sformatf("t1_pc%0d", i),    popped[i].pc,       32'(4 * i));
      chk($sformatf("t1_data%0d", i),  popped[i].data,     32'h11 + 32'(i));
      chk($sformatf("t1_fault%0d", i), 32'(popped[i].fault), 32'd0);
    end

    // ---- 2: backpressure fills exactly FIFO_DEPTH, one pop -> one request ----
    lat = 0; inst_ready = 1'b0;
    hold_reset();
    sys_rst = 1'b1;
    tick(15);
    chk("t2_nreq_full", 32'(ack_log.size()), 32'd4);
    chk("t2_req_low",   32'(imem_req),       32'd0);
    chk("t2_last_addr", ack_log[3],          32'hC);
    inst_ready = 1'b1;
    tick(1);
    inst_ready = 1'b0;
    tick(10);
    chk("t2_nreq_after", 32'(ack_log.size()), 32'd5);
    chk("t2_new_addr",   ack_log[4],          32'h10);
    chk("t2_req_low2",   32'(imem_req),       32'd0);
    chk("t2_npop",       32'(popped.size()),  32'd1);
    chk("t2_pop_pc",     popped[0].pc,        32'h0);

    // ---- 3: redirect while waiting on a slow ack -> drain ----
    lat = 5; inst_ready = 1'b1;
    hold_reset();
    sys_rst = 1'b1;
    tick(1);
    tick(1);
    redir_valid = 1'b1; redir_pc = 32'h100;
    tick(1);
    redir_valid = 1'b0;
    chk("t3_drain_req",   32'(imem_req), 32'd1);
    chk("t3_drain_addr",  imem_addr,     32'h0);
    tick(2);
    chk("t3_drain_req2",  32'(imem_req), 32'd1);
    chk("t3_drain_addr2", imem_addr,     32'h0);
    wait_pop(1, "t3_pop_timeout");
    chk("t3_log0",  ack_log[0],      32'h0);
    chk("t3_log1",  ack_log[1],      32'h100);
    chk("t3_pc",    popped[0].pc,    32'h100);
    chk("t3_data",  popped[0].data,  32'h51);
    chk("t3_fault", 32'(popped[0].fault), 32'd0);

    // ---- 4: redirect in the same cycle as the ack of 0x8 ----
    lat = 1; inst_ready = 1'b0;
    hold_reset();
    sys_rst = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (imem_ack && imem_addr == 32'h8) found = 1'b1;
      else tick(1);
    end
    chk("t4_ack8_seen", 32'(found), 32'd1);
    redir_valid = 1'b1; redir_pc = 32'h200;
    tick(1);
    redir_valid = 1'b0;
    chk("t4_req",  32'(imem_req), 32'd1);
    chk("t4_addr", imem_addr,     32'h200);
    inst_ready = 1'b1;
    wait_pop(2, "t4_pop_timeout");
    chk("t4_pc0",   popped[0].pc,   32'h200);
    chk("t4_data0", popped[0].data, 32'h91);
    chk("t4_pc1",   popped[1].pc,   32'h204);

    // ---- 5: misaligned redirect -> fault entry, halt, resume ----
    lat = 1; inst_ready = 1'b1;
    hold_reset();
    sys_rst = 1'b1;
    tick(1);
    redir_valid = 1'b1; redir_pc = 32'h302;
    tick(1);
    redir_valid = 1'b0;
    wait_pop(1, "t5_pop_timeout");
    chk("t5_pc",    popped[0].pc,         32'h302);
    chk("t5_data",  popped[0].data,       32'h13);
    chk("t5_fault", 32'(popped[0].fault), 32'd1);
    n_req = 0;
    repeat (10) begin
      tick(1);
      if (imem_req) n_req++;
    end
    chk("t5_halt_noreq", 32'(n_req),          32'd0);
    chk("t5_halt_npop",  32'(popped.size()),  32'd1);
    redir_valid = 1'b1; redir_pc = 32'h400;
    tick(1);
    redir_valid = 1'b0;
    chk("t5_resume_req",  32'(imem_req), 32'd1);
    chk("t5_resume_addr", imem_addr,     32'h400);
    wait_pop(2, "t5_pop2_timeout");
    chk("t5_pc1",    popped[1].pc,         32'h400);
    chk("t5_data1",  popped[1].data,       32'h111);
    chk("t5_fault1", 32'(popped[1].fault), 32'd0);

    // ---- 6: reset during a pending request with an ack inside reset ----
    lat = 1; inst_ready = 1'b0;
    hold_reset();
    sys_rst = 1'b1;
    tick(6);
    sys_rst = 1'b0; force_ack = 1'b1;
    tick(1);
    chk("t6_rst_req",   32'(imem_req),   32'd0);
    chk("t6_rst_addr",  imem_addr,       32'h0);
    chk("t6_rst_valid", 32'(inst_valid), 32'd0);
    tick(1);
    force_ack = 1'b0;
    chk("t6_rst_pc",    inst_pc,         32'h0);
    chk("t6_rst_data",  inst_data,       32'h0);
    ack_log.delete();
    popped.delete();
    inst_ready = 1'b1;
    sys_rst = 1'b1;
    tick(1);
    chk("t6_req",  32'(imem_req), 32'd1);
    chk("t6_addr", imem_addr,     32'h0);
    wait_pop(1, "t6_pop_timeout");
    chk("t6_log0", ack_log[0],     32'h0);
    chk("t6_pc",   popped[0].pc,   32'h0);
    chk("t6_data", popped[0].data, 32'h11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
